sync_sched: RTL and testbench

SYNC_SCHED -- requirements
Module: sync_sched

---
 rtl/sync_sched.sv | 141 ++++++++++++++
 tb/tb_sync_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_sched.sv
// Round-robin scheduler that serialises N requester words onto one shared bus
// toward a clock-crossing synchronizer, spacing strobes by a guard interval.
module sync_sched #(
  parameter int W     = 32,
  parameter int N     = 4,
  parameter int GUARD = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         data,
  output logic [N-1:0]           ack,
  output logic [W-1:0]           bus_out,
  output logic                   bus_strobe,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   last_id
);

  localparam int IDW   = $clog2(N);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       ack_q, ack_d;
  logic [W-1:0]       bus_q, bus_d;
  logic               strobe_q, strobe_d;
  logic [IDW-1:0]     last_q, last_d;

  // Arbitration: search from ptr upward, wrapping at N-1 (N need not be a power of 2).
  logic               found;
  logic [IDW-1:0]     win_id;
  logic [IDW-1:0]     idx;
  logic [N-1:0]       win_onehot;
  logic [W-1:0]       win_data;
  logic [IDW-1:0]     win_next;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
      idx = (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
    end

    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (win_id == IDW'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = data[i*W +: W];
      end
    end
    win_next = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    bus_d    = bus_q;
    strobe_d = strobe_q;
    last_d   = last_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          ack_d   = win_onehot;
          bus_d   = win_data;
          last_d  = win_id;
          ptr_d   = win_next;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ack_d    = '0;
        strobe_d = 1'b1;
        state_d  = STROBE;
      end
      STROBE: begin
        strobe_d = 1'b0;
        cnt_d    = CNT_W'(GUARD - 1);
        state_d  = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // Corrupted state register: recover to IDLE with both pulses quiet.
        state_d  = IDLE;
        ack_d    = '0;
        strobe_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      bus_q    <= '0;
      strobe_q <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      bus_q    <= bus_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
    end
  end

  assign ack        = ack_q;
  assign bus_out    = bus_q;
  assign bus_strobe = strobe_q;
  assign last_id    = last_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sync_sched.sv
// Scoreboard bench for sync_sched: directed stimulus pushes expected words,
// negedge monitors pop and compare on every bus_strobe.
module tb_sync_sched;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic [W-1:0]   bus_out;
  logic           bus_strobe;
  logic           busy;
  logic [IW-1:0]  last_id;

  logic [N-1:0]   g_req;
  logic [N*W-1:0] g_data;
  logic [N-1:0]   g_ack;
  logic [W-1:0]   g_bus_out;
  logic           g_strobe;
  logic           g_busy;
  logic [IW-1:0]  g_last_id;

  sync_sched #(.W(W), .N(N), .GUARD(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .bus_out(bus_out), .bus_strobe(bus_strobe), .busy(busy), .last_id(last_id)
  );

  sync_sched #(.W(W), .N(N), .GUARD(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .req(g_req), .data(g_data), .ack(g_ack),
    .bus_out(g_bus_out), .bus_strobe(g_strobe), .busy(g_busy), .last_id(g_last_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [W-1:0] word;
    int          gap;   // required edges since previous strobe, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  exp_t g_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int g_strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int g_last_strobe_cyc = 0;
  bit ack2_seen = 1'b0;
  logic [N-1:0] prev_ack = '0;
  logic [N-1:0] g_prev_ack = '0;
  logic [W-1:0] g_cur_exp = '0;
  bit g_have = 1'b0;
  exp_t mon_e;
  exp_t g_mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] word, input int gap);
    exp_t e;
    e.id = id; e.word = word; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic g_push(input logic [W-1:0] word, input int gap);
    exp_t e;
    e.id = 0; e.word = word; e.gap = gap;
    g_q.push_back(e);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int k = 0;
    while (strobe_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("strobe_wait", 64'(strobe_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  always @(posedge clk) cyc++;

  // Main-instance monitor: invariants every cycle, scoreboard pop on each strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_onehot_no_overlap",
            64'(((ack & (ack - 4'd1)) == '0) && !((ack != '0) && bus_strobe)), 64'd1);
      if (ack[2]) ack2_seen = 1'b1;
      if (bus_strobe) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("bus_out", 64'(bus_out), 64'(mon_e.word));
          check("last_id", 64'(last_id), 64'(mon_e.id));
          check("ack_before_strobe", 64'(prev_ack), 64'(1) << mon_e.id);
          if (mon_e.gap != 0) check("strobe_gap", 64'(cyc - last_strobe_cyc), 64'(mon_e.gap));
        end
        last_strobe_cyc = cyc;
      end
      prev_ack = ack;
    end else begin
      prev_ack = '0;
    end
  end

  // GUARD=1 instance monitor: strobe spacing and bus stability between grants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (g_strobe) begin
        g_strobe_cnt++;
        if (g_q.size() == 0) begin
          check("g_unexpected_strobe", 64'd1, 64'd0);
        end else begin
          g_mon_e = g_q.pop_front();
          check("g_bus_out", 64'(g_bus_out), 64'(g_mon_e.word));
          check("g_ack_before_strobe", 64'(g_prev_ack), 64'd1);
          if (g_mon_e.gap != 0) check("g_strobe_gap", 64'(cyc - g_last_strobe_cyc), 64'(g_mon_e.gap));
          g_cur_exp = g_mon_e.word;
          g_have    = 1'b1;
        end
        g_last_strobe_cyc = cyc;
      end else if (g_have && g_ack == '0) begin
        check("g_bus_stable", 64'(g_bus_out), 64'(g_cur_exp));
      end
      g_prev_ack = g_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n  = 1'b0;
    req    = '0;
    data   = '0;
    g_req  = '0;
    g_data = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_bus_out", 64'(bus_out), 64'd0);
    check("rst_strobe", 64'(bus_strobe), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_last_id", 64'(last_id), 64'd0);
    rst_n = 1'b1;

    // Single request latency and busy window.
    @(negedge clk);
    data[31:0] = 32'hA5A5_0001;
    req = 4'b0001;
    push(0, 32'hA5A5_0001, 0);
    @(negedge clk);
    req = '0;
    check("lat_ack", 64'(ack), 64'b0001);
    check("lat_bus_out", 64'(bus_out), 64'hA5A5_0001);
    check("lat_no_strobe_yet", 64'(bus_strobe), 64'd0);
    @(negedge clk);
    check("lat_strobe", 64'(bus_strobe), 64'd1);
    check("lat_ack_cleared", 64'(ack), 64'd0);
    repeat (5) @(negedge clk);
    check("lat_busy_e7", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat_busy_e8", 64'(busy), 64'd0);
    check("lat_bus_hold", 64'(bus_out), 64'hA5A5_0001);

    // Continuous 1111 from ptr=0: grants 0,1,2,3,0 eight edges apart.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    data = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    @(negedge clk);
    req = 4'b1111;
    push(0, 32'hA0A0_0000, 0);
    push(1, 32'hB1B1_0001, 8);
    push(2, 32'hC2C2_0002, 8);
    push(3, 32'hD3D3_0003, 8);
    push(0, 32'hA0A0_0000, 8);
    wait_strobes(strobe_cnt + 5, 60);
    req = '0;
    wait_idle(20);

    // Move ptr to 2, then 1001 must grant 3 before 0.
    @(negedge clk);
    req = 4'b0010;
    push(1, 32'hB1B1_0001, 0);
    @(negedge clk);
    req = '0;
    wait_strobes(strobe_cnt + 1, 20);
    wait_idle(20);
    @(negedge clk);
    req = 4'b1001;
    push(3, 32'hD3D3_0003, 0);
    push(0, 32'hA0A0_0000, 8);
    wait_strobes(strobe_cnt + 2, 40);
    req = '0;
    wait_idle(20);

    // A one-cycle request during HOLD is ignored.
    ack2_seen = 1'b0;
    @(negedge clk);
    req = 4'b0001;
    push(0, 32'hA0A0_0000, 0);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check("pulse_in_hold_busy", 64'(busy), 64'd1);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    base = strobe_cnt;
    repeat (20) @(negedge clk);
    check("pulse_no_ack2", 64'(ack2_seen), 64'd0);
    check("pulse_no_extra_strobe", 64'(strobe_cnt), 64'(base));

    // Reset asserted during the STROBE cycle aborts the transfer.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    check("abort_ack", 64'(ack), 64'b0100);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_strobe", 64'(bus_strobe), 64'd0);
    check("abort_ack_clr", 64'(ack), 64'd0);
    check("abort_bus_out", 64'(bus_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_last_id", 64'(last_id), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    base = strobe_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_strobe", 64'(strobe_cnt), 64'(base));
    // ptr back at 0 after reset: 0110 grants requester 1.
    req = 4'b0110;
    push(1, 32'hB1B1_0001, 0);
    @(negedge clk);
    req = '0;
    wait_strobes(strobe_cnt + 1, 20);
    wait_idle(20);

    // GUARD=1 instance: strobes 4 apart, bus stable while data input changes.
    @(negedge clk);
    g_data[31:0] = 32'h1111_0001;
    g_req = 4'b0001;
    g_push(32'h1111_0001, 0);
    @(negedge clk);
    g_data[31:0] = 32'h2222_0002;
    g_push(32'h2222_0002, 4);
    repeat (4) @(negedge clk);
    g_data[31:0] = 32'h3333_0003;
    g_push(32'h3333_0003, 4);
    repeat (4) @(negedge clk);
    g_req = '0;
    begin
      int k = 0;
      while ((g_strobe_cnt < 3 || g_busy !== 1'b0) && k < 30) begin
        @(negedge clk); #1;
        k++;
      end
    end
    check("g_strobe_count", 64'(g_strobe_cnt), 64'd3);
    check("g_idle", 64'(g_busy), 64'd0);
    repeat (3) @(negedge clk);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("g_q_drained", 64'(g_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
